// File: rtl/xs3_pkg.sv
// Shared types and constants for the excess-3 / BCD word decoder.
//   state_e         : word assembly state (IDLE, COLLECT, HOLD)
//   XS3_OFFSET      : excess-3 bias subtracted from a valid xs3 code
//   XS3_MIN/XS3_MAX : legal excess-3 code range (digits 0..9)
//   BCD_MAX         : largest legal plain-BCD code
//   ERR_CNT_W       : width of the optional invalid-digit counter
package xs3_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      HOLD    = 2'd2
   } state_e;

   localparam logic [3:0] XS3_OFFSET = 4'd3;
   localparam logic [3:0] XS3_MIN    = 4'b0011;
   localparam logic [3:0] XS3_MAX    = 4'b1100;
   localparam logic [3:0] BCD_MAX    = 4'd9;
   localparam int         ERR_CNT_W  = 8;

endpackage

// File: rtl/xs3_digit_decode.sv
// Combinational single-digit decoder.
//   code      : 4-bit coded digit, bit 3 = MSB
//   mode      : 1 = excess-3, 0 = plain BCD
//   digit     : decoded BCD digit (0 when the code is invalid)
//   digit_err : code is outside the legal range for the selected mode
module xs3_digit_decode
   import xs3_pkg::*;
(
   input  logic [3:0] code,
   input  logic       mode,
   output logic [3:0] digit,
   output logic       digit_err
);

   always_comb begin
      digit     = 4'd0;
      digit_err = 1'b0;
      if (mode) begin
         if ((code >= XS3_MIN) && (code <= XS3_MAX)) begin
            digit = code - XS3_OFFSET;
         end else begin
            digit_err = 1'b1;
         end
      end else begin
         if (code <= BCD_MAX) begin
            digit = code;
         end else begin
            digit_err = 1'b1;
         end
      end
   end

endmodule

// File: rtl/xs3_word_decoder.sv
// Receive-side word decoder: takes one coded digit per valid/ready handshake,
// decodes it (excess-3 or plain BCD, mode latched on the first digit of each
// word) and assembles NUM_DIGITS digits, first digit in the top nibble, into
// a packed BCD word with a sticky error flag, presented on a valid/ready port.
//
// Optional build macro XS3_ERR_CNT_EN adds err_cnt, a saturating count of
// every accepted invalid digit (including ones later flushed).
//
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   in_valid/in_ready     : digit handshake; in_mode, in_code carry the digit
//   in_flush              : drop the partially assembled word (ignored in HOLD)
//   out_valid/out_ready   : word handshake; out_word, out_err carry the word
//   err_cnt               : (XS3_ERR_CNT_EN only) invalid-digit count
//
// state   | meaning
// IDLE    | no digits held
// COLLECT | 1..NUM_DIGITS-1 digits held
// HOLD    | word complete, out_valid = 1
module xs3_word_decoder
   import xs3_pkg::*;
#(
   parameter int NUM_DIGITS = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    in_mode,
   input  logic [3:0]              in_code,
   input  logic                    in_flush,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [4*NUM_DIGITS-1:0] out_word,
   output logic                    out_err
`ifdef XS3_ERR_CNT_EN
   ,
   output logic [ERR_CNT_W-1:0]    err_cnt
`endif
);

   localparam int W     = 4 * NUM_DIGITS;
   localparam int CNT_W = $clog2(NUM_DIGITS + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_DIGITS - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [W-1:0]     word_q, word_d;
   logic             err_q, err_d;
   logic             mode_q, mode_d;

   logic             accept;
   logic             dec_mode;
   logic [3:0]       digit;
   logic             digit_err;

   // The first digit of a word decodes with the live mode bit; later digits
   // use the mode latched from that first digit.
   assign dec_mode = (state_q == IDLE) ? in_mode : mode_q;

   xs3_digit_decode u_dec (
      .code      (in_code),
      .mode      (dec_mode),
      .digit     (digit),
      .digit_err (digit_err)
   );

   assign in_ready  = rst_n && (state_q != HOLD);
   assign accept    = in_valid && in_ready;
   assign out_valid = (state_q == HOLD);
   assign out_word  = word_q;
   assign out_err   = err_q;

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      word_d  = word_q;
      err_d   = err_q;
      mode_d  = mode_q;
      case (state_q)
         IDLE, COLLECT: begin
            // Flush wins over a simultaneous accept: that digit is dropped.
            if (in_flush) begin
               state_d = IDLE;
               count_d = '0;
               err_d   = 1'b0;
            end else if (accept) begin
               if (state_q == IDLE) begin
                  mode_d = in_mode;
                  word_d = W'(digit);
                  err_d  = digit_err;
               end else begin
                  word_d = (word_q << 4) | W'(digit);
                  err_d  = err_q | digit_err;
               end
               count_d = count_q + CNT_W'(1);
               state_d = (count_q == LAST_CNT) ? HOLD : COLLECT;
            end
         end
         HOLD: begin
            if (out_ready) begin
               state_d = IDLE;
               count_d = '0;
            end
         end
         default: begin
            state_d = IDLE;
            count_d = '0;
         end
      endcase
   end

`ifdef XS3_ERR_CNT_EN
   logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

   // Counts on the accept itself, so a digit dropped by a flush still counts.
   always_comb begin
      err_cnt_d = err_cnt_q;
      if (accept && digit_err && (err_cnt_q != '1)) begin
         err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
      end
   end

   assign err_cnt = err_cnt_q;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         count_q   <= '0;
         word_q    <= '0;
         err_q     <= 1'b0;
         mode_q    <= 1'b0;
`ifdef XS3_ERR_CNT_EN
         err_cnt_q <= '0;
`endif
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         word_q    <= word_d;
         err_q     <= err_d;
         mode_q    <= mode_d;
`ifdef XS3_ERR_CNT_EN
         err_cnt_q <= err_cnt_d;
`endif
      end
   end

endmodule
